cpu_exec_ctrl: RTL
==================

# cpu_exec_ctrl

Execution controller for the picoMIPS CPU. It generates the CPU clock enable `cpu_en`, which gates PC update and register write-back, and sequences the CPU through halted, free-running, single-step and breakpoint-stopped operation. While the CPU is enabled it captures the ALU result bus and counts executed instructions. It sits between the board-level debug/control inputs and the `cpu` top level, and observes `ProgAddress` and `outport`.

## Interface
- `Psize`, default 6, program address width (matches program counter).
- `n`, default 8, data bus width (matches CPU datapath).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high master reset.
- `run_req`  in  1  level-sampled request to start free-running.
- `step_req`  in  1  request to execute exactly one instruction.
- `halt_req`  in  1  request to stop free-running.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  Psize  breakpoint program address.
- `pc`  in  Psize  current CPU program address.
- `result`  in  n  CPU ALU result (`outport`).
- `cpu_en`  out  1  CPU enable; combinational from state and inputs.
- `halted`  out  1  1 in IDLE or BRK.
- `bp_hit`  out  1  1 in BRK.
- `out_latch`  out  n  last `result` seen in an enabled cycle.
- `out_valid`  out  1  one-cycle pulse the cycle after each enabled cycle.
- `instr_count`  out  16  executed-instruction count, saturating.

## Operation
- States: IDLE, RUN, STEP, BRK. Encoded in 2 bits.
- Reset values: state IDLE, `skip`=1, `out_latch`=0, `out_valid`=0, `instr_count`=0. Outputs follow: `cpu_en`=0, `halted`=1, `bp_hit`=0.
- Breakpoint match: `bpm = bp_en & (pc == bp_addr) & ~skip`.
- `cpu_en = (state==STEP) | (state==RUN & ~halt_req & ~bpm)`.
- IDLE and BRK transitions:
  - `step_req` → STEP; this has priority over `run_req`.
  - Otherwise `run_req` → RUN.
  - `halt_req` is ignored in both states.
  - Entering RUN or STEP sets `skip`=1.
- STEP: `cpu_en`=1 for exactly one cycle, then → IDLE unconditionally. All requests are ignored during STEP.
- RUN:
  - `halt_req` → IDLE; the current cycle is not executed.
  - Otherwise `bpm` → BRK; the instruction at `bp_addr` is not executed.
  - Otherwise stay in RUN.
  - `halt_req` has priority over `bpm`.
  - `run_req` and `step_req` are ignored.
- `skip` clears after the first enabled cycle. Consequences:
  - The first instruction after any resume (run or step) always executes, even at `bp_addr`.
  - Breakpoints never fire on an instruction twice in a row.
- Every cycle with `cpu_en`=1:
  - `out_latch <= result`.
  - `out_valid <= 1`; otherwise `out_valid <= 0`.
  - `instr_count` increments, holding at 16'hFFFF.
- `instr_count` is not cleared by halt, breakpoint or resume; only `reset` clears it.
- Changing `bp_addr` or `bp_en` takes effect in the same cycle, because the match is combinational.

## Timing
- Request to enable latency:
  - A request sampled at edge k changes state at edge k.
  - `cpu_en` rises in cycle k+1.
  - The first instruction commits at edge k+1.
- Halt is zero-latency: `halt_req` high in a RUN cycle forces `cpu_en`=0 in that same cycle, and state is IDLE after the edge.
- Breakpoint is zero-latency: `cpu_en`=0 in the cycle where `pc==bp_addr`, and state is BRK after the edge.
- Output capture: `out_latch` and `out_valid` are valid one cycle after the enabled cycle.
- Reset asserted mid-RUN or mid-STEP:
  - `cpu_en` drops immediately (combinational from the async-cleared state).
  - All registers take their reset values with no clock edge.
- After reset deasserts, the block stays in IDLE until a request arrives.

## Test plan
- Reset, then no requests for 10 cycles → `cpu_en`=0, `halted`=1, `instr_count`=0, `out_valid`=0 throughout.
- From IDLE, `step_req` pulse with `result`=8'h5A → `cpu_en` high for 1 cycle, `out_latch`=8'h5A, one `out_valid` pulse, `instr_count`=1, back in IDLE. Repeat 3 times → `instr_count`=4.
- `run_req` pulse, hold 20 cycles, then `halt_req` → `cpu_en` low in the `halt_req` cycle, `instr_count`=20, `halted`=1.
- `bp_en`=1, `bp_addr`=6'd5, `pc` incrementing from 0, `run_req` → `cpu_en`=0 when `pc`=5, `bp_hit`=1, `instr_count`=5. Then `run_req` → instruction at 5 executes, no re-hit, RUN continues.
- In BRK at `pc`=5, assert `step_req` and `run_req` together → STEP wins, exactly 1 instruction executes, then IDLE.
- In RUN with `instr_count`=16'hFFFE, run 5 cycles → count saturates at 16'hFFFF. Assert `reset` between edges mid-RUN → `cpu_en`=0 immediately and `instr_count`=0.

Source files
------------

// File: rtl/cpu_exec_ctrl_if.sv
// Debug/control bundle between board-level controls, the picoMIPS core and cpu_exec_ctrl.
interface cpu_exec_ctrl_if #(
  parameter int Psize = 6,
  parameter int n     = 8
);
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             bp_en;
  logic [Psize-1:0] bp_addr;
  logic [Psize-1:0] pc;
  logic [n-1:0]     result;
  logic             cpu_en;
  logic             halted;
  logic             bp_hit;
  logic [n-1:0]     out_latch;
  logic             out_valid;
  logic [15:0]      instr_count;

  modport slave (
    input  run_req, step_req, halt_req, bp_en, bp_addr, pc, result,
    output cpu_en, halted, bp_hit, out_latch, out_valid, instr_count
  );

  modport master (
    output run_req, step_req, halt_req, bp_en, bp_addr, pc, result,
    input  cpu_en, halted, bp_hit, out_latch, out_valid, instr_count
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// picoMIPS execution controller: gates the CPU clock enable through halted, run,
// single-step and breakpoint states, and captures results / counts instructions.
module cpu_exec_ctrl #(
  parameter int Psize = 6,
  parameter int n     = 8
) (
  input  logic           clk,
  input  logic           reset,
  cpu_exec_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] BRK  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         skip_q, skip_d;
  logic [n-1:0] out_latch_q;
  logic         out_valid_q;
  logic [15:0]  cnt_q;
  logic         bpm;
  logic         cpu_en;
  logic         resume;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // skip masks the breakpoint on the first instruction after a resume
  assign bpm    = bus.bp_en & (bus.pc == bus.bp_addr) & ~skip_q;
  assign cpu_en = (state_q == STEP) | ((state_q == RUN) & ~bus.halt_req & ~bpm);
  assign resume = ((state_q == IDLE) | (state_q == BRK)) & (bus.step_req | bus.run_req);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BRK: begin
        if (bus.step_req)     state_d = STEP;
        else if (bus.run_req) state_d = RUN;
      end
      STEP: state_d = IDLE;
      RUN: begin
        if (bus.halt_req) state_d = IDLE;
        else if (bpm)     state_d = BRK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    skip_d = skip_q;
    if (resume)      skip_d = 1'b1;
    else if (cpu_en) skip_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      skip_q      <= 1'b1;
      out_latch_q <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      out_valid_q <= cpu_en;
      if (cpu_en) begin
        out_latch_q <= bus.result;
        cnt_q       <= sat_inc(cnt_q);
      end
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.halted      = (state_q == IDLE) | (state_q == BRK);
  assign bus.bp_hit      = (state_q == BRK);
  assign bus.out_latch   = out_latch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.instr_count = cnt_q;

endmodule
